// File: rtl/regfile_sb.sv
// regfile_sb: parametrised two-read/one-write register file with a
// post-reset clear sequencer, same-cycle write-to-read bypass and a
// pending-write scoreboard that flags operands still awaiting a load.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = (1 << ADDR_W) - 1,
  parameter int XP_REG   = (1 << ADDR_W) - 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              RA2SEL,
  input  logic              WASEL,
  input  logic              WERF,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic [ADDR_W-1:0] RC,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              PEND_SET,
  input  logic [ADDR_W-1:0] PEND_ADDR,
  output logic [DATA_W-1:0] RADATA,
  output logic [DATA_W-1:0] RBDATA,
  output logic              STALL,
  output logic              BUSY
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] XP_A   = ADDR_W'(XP_REG);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;

  logic [ADDR_W-1:0] wa;
  logic [ADDR_W-1:0] rb;
  logic              wr_en;
  logic              byp_a;
  logic              byp_b;

  // Effective addresses and qualified write enable
  always_comb begin
    wa    = WASEL ? XP_A : RC;
    rb    = RA2SEL ? RC : RB;
    wr_en = (state == RUN) && WERF && (wa != ZERO_A);
    byp_a = WERF && (wa == RA);
    byp_b = WERF && (wa == rb);
  end

  // State register and clear counter
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) cnt <= cnt + 1'b1;
    end
  end

  // Next state: leave CLEAR once the last index has been zeroed
  always_comb begin
    state_nxt = state;
    if (state == CLEAR && cnt == '1) state_nxt = RUN;
  end

  // Storage: clear sequencer owns the write port while in CLEAR
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (state == CLEAR) mem[cnt] <= '0;
      else if (wr_en)     mem[wa]  <= WDATA;
    end
  end

  // Scoreboard: write clears, load issue sets; set applied last so it wins
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend <= '0;
    end else if (state == RUN) begin
      if (wr_en) pend[wa] <= 1'b0;
      if (PEND_SET && PEND_ADDR != ZERO_A) pend[PEND_ADDR] <= 1'b1;
    end
  end

  // Outputs: zero register, then bypass, then array; all quiet while clearing
  always_comb begin
    BUSY   = (state == CLEAR);
    RADATA = '0;
    RBDATA = '0;
    STALL  = 1'b0;
    if (state == RUN) begin
      if (RA != ZERO_A) RADATA = byp_a ? WDATA : mem[RA];
      if (rb != ZERO_A) RBDATA = byp_b ? WDATA : mem[rb];
      STALL = (pend[RA] && RA != ZERO_A && !byp_a) ||
              (pend[rb] && rb != ZERO_A && !byp_b);
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed steps followed by random traffic, each
// cycle checked against a behavioural register-file model.
module tb_regfile_sb;

  logic        CLK = 1'b0;
  logic        RESET, RA2SEL, WASEL, WERF, PEND_SET;
  logic [4:0]  RA, RB, RC, PEND_ADDR;
  logic [31:0] WDATA;
  logic [31:0] RADATA, RBDATA;
  logic        STALL, BUSY;

  regfile_sb #(.DATA_W(32), .ADDR_W(5)) dut (
    .CLK(CLK), .RESET(RESET), .RA2SEL(RA2SEL), .WASEL(WASEL), .WERF(WERF),
    .RA(RA), .RB(RB), .RC(RC), .WDATA(WDATA), .PEND_SET(PEND_SET),
    .PEND_ADDR(PEND_ADDR), .RADATA(RADATA), .RBDATA(RBDATA),
    .STALL(STALL), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Reference model
  logic [31:0] mref [32];
  bit          pref [32];
  int          clear_left;
  bit          mvalid;
  string       phase;

  int n_assert;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: observed %h expected %h", phase, tag, obs, exp);
    end
  endtask

  function automatic int eff_wa();
    return WASEL ? 30 : int'(RC);
  endfunction

  function automatic int eff_rb();
    return RA2SEL ? int'(RC) : int'(RB);
  endfunction

  function automatic logic [31:0] exp_read(input int x);
    if (clear_left > 0) return 32'h0;
    if (x == 31) return 32'h0;
    if (WERF && eff_wa() == x) return WDATA;
    return mref[x];
  endfunction

  function automatic bit exp_hit(input int x);
    return pref[x] && x != 31 && !(WERF && eff_wa() == x);
  endfunction

  // One clock: check combinational outputs mid-cycle, then advance the model
  task automatic cycle();
    int wa;
    @(negedge CLK);
    if (mvalid) begin
      chk("BUSY",   {31'b0, BUSY},  {31'b0, clear_left > 0});
      chk("STALL",  {31'b0, STALL},
          {31'b0, (clear_left == 0) && (exp_hit(int'(RA)) || exp_hit(eff_rb()))});
      chk("RADATA", RADATA, exp_read(int'(RA)));
      chk("RBDATA", RBDATA, exp_read(eff_rb()));
    end
    @(posedge CLK);
    wa = eff_wa();
    if (RESET) begin
      mvalid     = 1'b1;
      clear_left = 32;
      foreach (pref[i]) pref[i] = 1'b0;
    end else if (mvalid && clear_left > 0) begin
      clear_left--;
      if (clear_left == 0) foreach (mref[i]) mref[i] = 32'h0;
    end else if (mvalid) begin
      if (WERF && wa != 31) begin
        mref[wa] = WDATA;
        pref[wa] = 1'b0;
      end
      if (PEND_SET && PEND_ADDR != 5'd31) pref[PEND_ADDR] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    RESET = 0; RA2SEL = 0; WASEL = 0; WERF = 0; PEND_SET = 0;
    PEND_ADDR = 0; WDATA = 0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    idle(); RA = a; RB = b; RC = 0;
    cycle();
  endtask

  task automatic wr(input logic [4:0] c, input logic [31:0] d);
    idle(); WERF = 1; RC = c; WDATA = d; RA = 0; RB = 0;
    cycle();
  endtask

  initial begin
    n_assert = 0; n_fail = 0; mvalid = 0; clear_left = 0;
    foreach (mref[i]) mref[i] = 32'h0;
    foreach (pref[i]) pref[i] = 1'b0;
    RA = 0; RB = 0; RC = 0;

    phase = "reset";
    idle(); RESET = 1;
    repeat (2) cycle();

    phase = "clear";
    idle();
    for (int i = 0; i < 32; i++) begin
      if (i == 5) begin WERF = 1; RC = 5; WDATA = 32'hDEAD; RA = 5; RB = 5; end
      else begin WERF = 0; RA = 5'(i); RB = 5'(31 - i); end
      PEND_SET = (i == 7); PEND_ADDR = 5'd6;
      cycle();
    end

    phase = "readall";
    for (int i = 0; i < 32; i++) rd(5'(i), 5'(i));

    phase = "wr_rd_zero";
    wr(5'd3, 32'h12345678);
    rd(5'd3, 5'd3);
    wr(5'd31, 32'hFFFFFFFF);
    rd(5'd31, 5'd31);
    idle(); WERF = 1; WASEL = 1; RC = 5'd3; WDATA = 32'hA5A5A5A5; RA = 0; RB = 0;
    cycle();
    rd(5'd30, 5'd3);

    phase = "bypass";
    idle(); WERF = 1; RC = 5'd7; WDATA = 32'h55; RA = 5'd7; RB = 5'd7;
    cycle();
    idle(); RA2SEL = 1; RB = 5'd2; RC = 5'd7; RA = 5'd2;
    cycle();

    phase = "scoreboard";
    idle(); PEND_SET = 1; PEND_ADDR = 5'd4; RA = 0; RB = 0;
    cycle();
    rd(5'd4, 5'd0);
    idle(); WERF = 1; RC = 5'd4; WDATA = 32'hCAFE0004; RA = 5'd4; RB = 5'd0;
    cycle();
    rd(5'd4, 5'd0);
    idle(); PEND_SET = 1; PEND_ADDR = 5'd31;
    cycle();
    rd(5'd31, 5'd31);

    phase = "collision";
    idle(); PEND_SET = 1; PEND_ADDR = 5'd9; WERF = 1; RC = 5'd9; WDATA = 32'h9; RA = 0; RB = 0;
    cycle();
    rd(5'd9, 5'd0);
    rd(5'd0, 5'd9);

    phase = "midclear";
    idle(); PEND_SET = 1; PEND_ADDR = 5'd12;
    cycle();
    idle(); RESET = 1;
    cycle();
    idle();
    repeat (10) cycle();
    RESET = 1;
    cycle();
    idle(); RA = 5'd12; RB = 5'd9;
    repeat (33) cycle();
    rd(5'd12, 5'd9);

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      RESET     = ($urandom_range(0, 199) == 0);
      RA2SEL    = $urandom_range(0, 1) != 0;
      WASEL     = ($urandom_range(0, 7) == 0);
      WERF      = $urandom_range(0, 1) != 0;
      PEND_SET  = ($urandom_range(0, 2) == 0);
      RA        = 5'($urandom_range(0, 31));
      RB        = 5'($urandom_range(0, 31));
      RC        = 5'($urandom_range(0, 31));
      PEND_ADDR = 5'($urandom_range(0, 31));
      WDATA     = $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
